// File: rtl/crop_pkg.sv
// Shared types and constants for the crop pipeline sequencer.
package crop_pkg;

  // Sequencer states; encoding is exported on the debug state port.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_BB_GO,
    ST_BB_WLO,
    ST_BB_WAIT,
    ST_CHECK,
    ST_CR_GO,
    ST_CR_WLO,
    ST_CR_WAIT,
    ST_HDR,
    ST_DONE,
    ST_ERROR
  } crop_state_t;

  // Abort reasons reported on err_code.
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_EMPTY   = 2'd1;
  localparam logic [1:0] ERR_RANGE   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // BMP file constants.
  localparam int HDR_BYTES = 54;
  localparam int DIB_SIZE  = 40;
  localparam int BPP       = 24;
  localparam int PPM       = 2835;

  // 24-bpp BMP rows are padded up to a multiple of four bytes.
  function automatic logic [13:0] row_bytes(input logic [10:0] w);
    return (14'(w) * 14'd3 + 14'd3) & ~14'd3;
  endfunction

endpackage

// File: rtl/crop_controller_bmp_header_gen.sv
// Combinational BMP header byte lookup: byte n of the 54-byte header
// for a 24-bpp image of the given size. Multi-byte fields are little-endian.
module bmp_header_gen
  import crop_pkg::*;
(
  input  logic [5:0]  i_n,
  input  logic [10:0] i_w,
  input  logic [10:0] i_h,
  input  logic [31:0] i_img,
  input  logic [31:0] i_fsz,
  output logic [7:0]  o_byte
);

  localparam logic [15:0] C_PPM = 16'(PPM);

  // Select the header byte for index i_n; every unlisted byte is zero.
  always_comb begin
    o_byte = 8'h00;
    case (i_n)
      6'd0:  o_byte = 8'h42;                 // 'B'
      6'd1:  o_byte = 8'h4D;                 // 'M'
      6'd2:  o_byte = i_fsz[7:0];
      6'd3:  o_byte = i_fsz[15:8];
      6'd4:  o_byte = i_fsz[23:16];
      6'd5:  o_byte = i_fsz[31:24];
      6'd10: o_byte = 8'(HDR_BYTES);         // pixel data offset
      6'd14: o_byte = 8'(DIB_SIZE);
      6'd18: o_byte = i_w[7:0];
      6'd19: o_byte = {5'b0, i_w[10:8]};
      6'd22: o_byte = i_h[7:0];
      6'd23: o_byte = {5'b0, i_h[10:8]};
      6'd26: o_byte = 8'd1;                  // colour planes
      6'd28: o_byte = 8'(BPP);
      6'd34: o_byte = i_img[7:0];
      6'd35: o_byte = i_img[15:8];
      6'd36: o_byte = i_img[23:16];
      6'd37: o_byte = i_img[31:24];
      6'd38: o_byte = C_PPM[7:0];
      6'd39: o_byte = C_PPM[15:8];
      6'd42: o_byte = C_PPM[7:0];
      6'd43: o_byte = C_PPM[15:8];
      default: o_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/crop_controller.sv
// Crop pipeline sequencer: runs the bounding-box engine, validates and
// latches its box, runs the cropper, then writes the BMP header.
//
// Handshake: bb_start/cr_start are one-cycle pulses; bb_done/cr_done are
// levels from the engines. A done level is only honoured after it has been
// seen low once since the matching start, so a done left high by a previous
// run never completes the current one.
module crop_controller
  import crop_pkg::*;
#(
  parameter int WIDTH   = 100,
  parameter int HEIGHT  = 100,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic        bb_start,
  input  logic        bb_done,
  input  logic [10:0] bb_xMin,
  input  logic [10:0] bb_xMax,
  input  logic [10:0] bb_yMin,
  input  logic [10:0] bb_yMax,
  input  logic [31:0] bb_readAddr,
  output logic        cr_start,
  input  logic        cr_done,
  output logic [10:0] cr_xMin,
  output logic [10:0] cr_xMax,
  output logic [10:0] cr_yMin,
  output logic [10:0] cr_yMax,
  input  logic [31:0] cr_readAddr,
  input  logic [31:0] cr_writeAddr,
  input  logic [15:0] cr_wrdata,
  input  logic        cr_wren,
  output logic [31:0] src_addr,
  output logic [31:0] dst_addr,
  output logic [15:0] dst_wrdata,
  output logic        dst_wren,
  output logic [3:0]  dbg_state
);

  crop_state_t r_state;
  logic        r_done;
  logic        r_error;
  logic [1:0]  r_err_code;
  logic        r_bb_start;
  logic        r_cr_start;
  logic [10:0] r_cr_xmin;
  logic [10:0] r_cr_xmax;
  logic [10:0] r_cr_ymin;
  logic [10:0] r_cr_ymax;
  logic [10:0] r_w;
  logic [10:0] r_h;
  logic [31:0] r_img;
  logic [31:0] r_fsz;
  logic [5:0]  r_hdr_n;
  logic [31:0] r_wdog;

  logic [10:0] w_w;
  logic [10:0] w_h;
  logic [13:0] w_row;
  logic [31:0] w_img;
  logic [31:0] w_fsz;
  logic        w_empty;
  logic        w_range;
  logic        w_wdog_exp;
  logic        w_hdr_last;
  logic [7:0]  w_hdr_byte;

  // Derived image geometry from the latched box (valid when the box is sane).
  assign w_w        = r_cr_xmax - r_cr_xmin + 11'd1;
  assign w_h        = r_cr_ymax - r_cr_ymin + 11'd1;
  assign w_row      = row_bytes(w_w);
  assign w_img      = 32'(w_row) * 32'(w_h);
  assign w_fsz      = w_img + 32'(HDR_BYTES);
  assign w_empty    = (r_cr_xmin > r_cr_xmax) || (r_cr_ymin > r_cr_ymax);
  assign w_range    = (32'(r_cr_xmax) >= 32'(WIDTH)) || (32'(r_cr_ymax) >= 32'(HEIGHT));
  // The current wait cycle is the TIMEOUT-th one since the last *_GO.
  assign w_wdog_exp = (r_wdog == 32'(TIMEOUT - 1));
  assign w_hdr_last = (r_hdr_n == 6'(HDR_BYTES - 1));

  bmp_header_gen u_hdr (
    .i_n    (r_hdr_n),
    .i_w    (r_w),
    .i_h    (r_h),
    .i_img  (r_img),
    .i_fsz  (r_fsz),
    .o_byte (w_hdr_byte)
  );

  // Main sequencer with registered status, start pulses, box and sizes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= ERR_NONE;
      r_bb_start <= 1'b0;
      r_cr_start <= 1'b0;
      r_cr_xmin  <= '0;
      r_cr_xmax  <= '0;
      r_cr_ymin  <= '0;
      r_cr_ymax  <= '0;
      r_w        <= '0;
      r_h        <= '0;
      r_img      <= '0;
      r_fsz      <= '0;
      r_hdr_n    <= '0;
      r_wdog     <= '0;
    end else begin
      r_bb_start <= 1'b0;
      r_cr_start <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            r_state    <= ST_BB_GO;
            r_bb_start <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
          end
        end
        ST_BB_GO: begin
          r_wdog  <= '0;
          r_state <= ST_BB_WLO;
        end
        ST_BB_WLO: begin
          if (w_wdog_exp) begin
            r_state    <= ST_ERROR;
            r_error    <= 1'b1;
            r_err_code <= ERR_TIMEOUT;
          end else begin
            r_wdog <= r_wdog + 32'd1;
            if (!bb_done) r_state <= ST_BB_WAIT;
          end
        end
        ST_BB_WAIT: begin
          if (bb_done) begin
            r_cr_xmin <= bb_xMin;
            r_cr_xmax <= bb_xMax;
            r_cr_ymin <= bb_yMin;
            r_cr_ymax <= bb_yMax;
            r_state   <= ST_CHECK;
          end else if (w_wdog_exp) begin
            r_state    <= ST_ERROR;
            r_error    <= 1'b1;
            r_err_code <= ERR_TIMEOUT;
          end else begin
            r_wdog <= r_wdog + 32'd1;
          end
        end
        ST_CHECK: begin
          if (w_empty) begin
            r_state    <= ST_ERROR;
            r_error    <= 1'b1;
            r_err_code <= ERR_EMPTY;
          end else if (w_range) begin
            r_state    <= ST_ERROR;
            r_error    <= 1'b1;
            r_err_code <= ERR_RANGE;
          end else begin
            r_w        <= w_w;
            r_h        <= w_h;
            r_img      <= w_img;
            r_fsz      <= w_fsz;
            r_state    <= ST_CR_GO;
            r_cr_start <= 1'b1;
          end
        end
        ST_CR_GO: begin
          r_wdog  <= '0;
          r_state <= ST_CR_WLO;
        end
        ST_CR_WLO: begin
          if (w_wdog_exp) begin
            r_state    <= ST_ERROR;
            r_error    <= 1'b1;
            r_err_code <= ERR_TIMEOUT;
          end else begin
            r_wdog <= r_wdog + 32'd1;
            if (!cr_done) r_state <= ST_CR_WAIT;
          end
        end
        ST_CR_WAIT: begin
          if (cr_done) begin
            r_hdr_n <= '0;
            r_state <= ST_HDR;
          end else if (w_wdog_exp) begin
            r_state    <= ST_ERROR;
            r_error    <= 1'b1;
            r_err_code <= ERR_TIMEOUT;
          end else begin
            r_wdog <= r_wdog + 32'd1;
          end
        end
        ST_HDR: begin
          if (w_hdr_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_hdr_n <= r_hdr_n + 6'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Memory port steering: source read port and destination write port.
  always_comb begin
    src_addr   = bb_readAddr;
    dst_addr   = '0;
    dst_wrdata = '0;
    dst_wren   = 1'b0;
    if (r_state == ST_CR_GO || r_state == ST_CR_WLO || r_state == ST_CR_WAIT) begin
      src_addr = cr_readAddr;
    end
    if (r_state == ST_HDR) begin
      dst_addr   = {26'b0, r_hdr_n};
      dst_wrdata = {8'h00, w_hdr_byte};
      dst_wren   = 1'b1;
    end else if (r_state == ST_CR_WLO || r_state == ST_CR_WAIT) begin
      dst_addr   = cr_writeAddr;
      dst_wrdata = cr_wrdata;
      dst_wren   = cr_wren;
    end
  end

  assign done      = r_done;
  assign error     = r_error;
  assign err_code  = r_err_code;
  assign bb_start  = r_bb_start;
  assign cr_start  = r_cr_start;
  assign cr_xMin   = r_cr_xmin;
  assign cr_xMax   = r_cr_xmax;
  assign cr_yMin   = r_cr_ymin;
  assign cr_yMax   = r_cr_ymax;
  assign dbg_state = r_state;

endmodule
